// File: rtl/i2c_target_regs.sv
// I2C target with an internal 8-bit register file: pointer write, burst write,
// and auto-incrementing reads. Raw SCL/SDA are oversampled on i_clk; SDA is driven open-drain.
module i2c_target_regs #(
  parameter logic [6:0] DEVICE_ADDR = 7'h11,
  parameter int         NUM_REGS    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_wr_strobe,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  logic [2:0] scl_q, sda_q;  // [0],[1] synchronizer, [2] edge-detect history
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       ptr_loaded_q, ptr_loaded_d;
  logic       rw_q, rw_d;
  logic       ack_drv_q, ack_drv_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       strobe_q, strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic       scl_rise, scl_fall, start_evt, stop_evt;
  logic       in_range;
  logic [7:0] byte_in, rd_byte;

  // Bus idles high, so the synchronizers reset to 1 to avoid a phantom edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], i_scl};
      sda_q <= {sda_q[1:0], i_sda};
    end
  end

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_evt =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_evt  =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];

  assign byte_in  = {shift_q[6:0], sda_q[1]};
  assign in_range = ({1'b0, ptr_q} < 9'(NUM_REGS));
  assign rd_byte  = in_range ? regs_q[ptr_q[IW-1:0]] : 8'hFF;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    ptr_d        = ptr_q;
    ptr_loaded_d = ptr_loaded_q;
    rw_d         = rw_q;
    ack_drv_d    = ack_drv_q;
    oe_d         = oe_q;
    busy_d       = busy_q;
    strobe_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;

    if (start_evt || stop_evt) begin
      state_d      = start_evt ? S_ADDR : S_IDLE;
      cnt_d        = 3'd0;
      oe_d         = 1'b0;
      busy_d       = 1'b0;
      ptr_loaded_d = 1'b0;
      ack_drv_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ack_drv_d = 1'b0;
              if (state_q == S_ADDR) begin
                if (byte_in[7:1] == DEVICE_ADDR) begin
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                  state_d = S_ADDR_ACK;
                end else begin
                  state_d = S_IGNORE;
                end
              end else if (state_q == S_PTR) begin
                ptr_d        = byte_in;
                ptr_loaded_d = 1'b1;
                state_d      = S_PTR_ACK;
              end else begin
                if (in_range) begin
                  regs_d[ptr_q[IW-1:0]] = byte_in;
                  strobe_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_in;
                end
                ptr_d   = ptr_q + 8'd1;
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        // First fall after the byte starts the ACK, the second ends it.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              oe_d      = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              cnt_d     = 3'd0;
              if (rw_q) begin
                shift_d = rd_byte;
                oe_d    = ~rd_byte[7];
                state_d = S_RDATA;
              end else begin
                oe_d    = 1'b0;
                state_d = ptr_loaded_q ? S_WDATA : S_PTR;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              oe_d      = 1'b0;
              ack_drv_d = 1'b0;
              state_d   = S_RDATA_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        // ack_drv_q doubles as "master ACKed, reload on the next fall".
        S_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_q[1]) begin
              state_d = S_IGNORE;
            end else begin
              ptr_d     = ptr_q + 8'd1;
              ack_drv_d = 1'b1;
            end
          end else if (scl_fall && ack_drv_q) begin
            ack_drv_d = 1'b0;
            cnt_d     = 3'd0;
            shift_d   = rd_byte;
            oe_d      = ~rd_byte[7];
            state_d   = S_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      shift_q      <= 8'd0;
      ptr_q        <= 8'd0;
      ptr_loaded_q <= 1'b0;
      rw_q         <= 1'b0;
      ack_drv_q    <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      strobe_q     <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ptr_q        <= ptr_d;
      ptr_loaded_q <= ptr_loaded_d;
      rw_q         <= rw_d;
      ack_drv_q    <= ack_drv_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      strobe_q     <= strobe_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // NOTE: the register file is reset because software expects all-zero contents after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign o_sda_oe    = oe_q;
  assign o_busy      = busy_q;
  assign o_wr_strobe = strobe_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;

endmodule
